// File: rtl/jtbubl_snd_comm.sv
// jtbubl_snd_comm -- sound-board end of the main<->sound latch protocol.
// Captures the main CPU command, raises NMI on the sound Z80, returns the
// reply byte/strobe and stretches the sound CPU reset.
// Optional feature: define JTBUBL_SNDFIFO_EN to replace the single command
// register with a 2**FIFO_AW-deep command FIFO with sticky overflow flag.
module jtbubl_snd_comm #(
   parameter int unsigned RST_LEN = 16,
   parameter int unsigned FIFO_AW = 2
) (
   input  logic       clk24,
   input  logic       rst,
   // main board side
   input  logic [7:0] snd_latch,
   input  logic       snd_stb,
   input  logic       snd_rstn,
   output logic [7:0] main_latch,
   output logic       main_stb,
   output logic       snd_flag,
   // sound CPU bus
   input  logic       snd_cs,
   input  logic [1:0] snd_addr,
   input  logic       snd_rd_n,
   input  logic       snd_wr_n,
   input  logic [7:0] snd_dout,
   output logic [7:0] snd_din,
   output logic       snd_nmi_n,
   output logic       snd_cpu_rst
);

   logic       stb_l, rd_l, wr_l;
   logic       rd_act, wr_act;
   logic       cap_ev, rd_ev, wr_ev;
   logic       rd0_ev, wr0_ev, wr1_ev, wr2_ev;
   logic       pending, pending_nx;
   logic       nmi_en, nmi_en_nx;
   logic       stb_seen;
   logic [7:0] cnt;
   logic [7:0] rd0_data;
   logic       ovf_bit;

   assign rd_act = snd_cs & ~snd_rd_n;
   assign wr_act = snd_cs & ~snd_wr_n;

   // One event per access; the sound side is deaf while its CPU is in reset.
   assign cap_ev = snd_stb & ~stb_l;
   assign rd_ev  = rd_act & ~rd_l & ~snd_cpu_rst;
   assign wr_ev  = wr_act & ~wr_l & ~snd_cpu_rst;
   assign rd0_ev = rd_ev & (snd_addr == 2'd0);
   assign wr0_ev = wr_ev & (snd_addr == 2'd0);
   assign wr1_ev = wr_ev & (snd_addr == 2'd1);
   assign wr2_ev = wr_ev & (snd_addr == 2'd2);

   assign snd_cpu_rst = (cnt != 8'd0) | ~snd_rstn;
   assign snd_flag    = pending;

   // Next NMI enable: set/clear writes, forced off while the sound CPU is held.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      nmi_en_nx = nmi_en;
      if (wr1_ev)      nmi_en_nx = 1'b1;
      if (wr2_ev)      nmi_en_nx = 1'b0;
      if (snd_cpu_rst) nmi_en_nx = 1'b0;
   end

`ifdef JTBUBL_SNDFIFO_EN
   localparam int unsigned DEPTH = 1 << FIFO_AW;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count, count_nx;
   logic [7:0]         last_pop;
   logic               ovf;
   logic               push, pop, full;

   assign full     = (count == (FIFO_AW+1)'(DEPTH));
   assign pop      = rd0_ev & (count != '0);
   // a full FIFO still accepts a push when a pop frees a slot in the same cycle
   assign push     = cap_ev & (~full | pop);
   assign count_nx = count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
   assign pending_nx = (count_nx != '0);
   // an empty read returns the last byte popped
   assign rd0_data = pop ? mem[rd_ptr] : last_pop;
   assign ovf_bit  = ovf;

   // FIFO storage
   always_ff @(posedge clk24) begin
      // NOTE: storage is not reset; count/pointers alone define what is valid.
      if (push) mem[wr_ptr] <= snd_latch;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk24) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_pop <= 8'd0;
         ovf      <= 1'b0;
      end else begin
         count <= count_nx;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            last_pop <= mem[rd_ptr];
         end
         if (cap_ev & ~push) ovf <= 1'b1;
      end
   end
`else
   logic [7:0] cmd;

   assign rd0_data = cmd;
   assign ovf_bit  = 1'b1;

   // Pending flag: a capture in the same cycle as the read-clear wins.
   always_comb begin
      pending_nx = pending;
      if (rd0_ev) pending_nx = 1'b0;
      if (cap_ev) pending_nx = 1'b1;
   end

   // Command register, newest capture overwrites
   always_ff @(posedge clk24) begin
      if (rst)         cmd <= 8'd0;
      else if (cap_ev) cmd <= snd_latch;
   end
`endif

   // Edge detectors, reset stretch, NMI, status and reply registers
   always_ff @(posedge clk24) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         // detectors reset to "already high" so a level held across rst fires nothing
         stb_l      <= 1'b1;
         rd_l       <= 1'b1;
         wr_l       <= 1'b1;
         cnt        <= 8'(RST_LEN);
         pending    <= 1'b0;
         nmi_en     <= 1'b0;
         snd_nmi_n  <= 1'b1;
         stb_seen   <= 1'b0;
         main_latch <= 8'd0;
         main_stb   <= 1'b0;
      end else begin
         stb_l   <= snd_stb;
         rd_l    <= rd_act;
         wr_l    <= wr_act;
         if (!snd_rstn)          cnt <= 8'(RST_LEN);
         else if (cnt != 8'd0)   cnt <= cnt - 8'd1;
         pending <= pending_nx;
         nmi_en  <= nmi_en_nx;
         // a read of the command register releases NMI for one clk so a
         // still-pending command produces a fresh falling edge
         snd_nmi_n <= ~(pending_nx & nmi_en_nx & ~rd0_ev);
         if (cap_ev)      stb_seen <= 1'b0;
         else if (wr0_ev) stb_seen <= 1'b1;
         if (wr0_ev) main_latch <= snd_dout;
         main_stb <= wr0_ev;
      end
   end

   // Registered read data, idle value 8'hff
   always_ff @(posedge clk24) begin
      if (rst || !rd_act || snd_cpu_rst) snd_din <= 8'hff;
      else begin
         case (snd_addr)
            2'd0:    snd_din <= rd0_data;
            2'd1:    snd_din <= {ovf_bit, 5'h1f, stb_seen, pending};
            default: snd_din <= 8'hff;
         endcase
      end
   end

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Directed self-checking bench for jtbubl_snd_comm (default build; the FIFO
// scenario is compiled in when JTBUBL_SNDFIFO_EN is defined).
module tb_jtbubl_snd_comm;
   localparam int RST_LEN = 16;

   logic       clk24 = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] snd_latch = 8'd0;
   logic       snd_stb = 1'b0;
   logic       snd_rstn = 1'b1;
   logic [7:0] main_latch;
   logic       main_stb;
   logic       snd_flag;
   logic       snd_cs = 1'b0;
   logic [1:0] snd_addr = 2'd0;
   logic       snd_rd_n = 1'b1;
   logic       snd_wr_n = 1'b1;
   logic [7:0] snd_dout = 8'd0;
   logic [7:0] snd_din;
   logic       snd_nmi_n;
   logic       snd_cpu_rst;

   int n_vec = 0;
   int n_err = 0;

   jtbubl_snd_comm #(.RST_LEN(RST_LEN), .FIFO_AW(2)) dut (
      .clk24(clk24), .rst(rst),
      .snd_latch(snd_latch), .snd_stb(snd_stb), .snd_rstn(snd_rstn),
      .main_latch(main_latch), .main_stb(main_stb), .snd_flag(snd_flag),
      .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_rd_n(snd_rd_n), .snd_wr_n(snd_wr_n),
      .snd_dout(snd_dout), .snd_din(snd_din), .snd_nmi_n(snd_nmi_n),
      .snd_cpu_rst(snd_cpu_rst)
   );

   always #5 clk24 = ~clk24;

   // inputs change and outputs are sampled at the falling edge
   task automatic tick();
      @(posedge clk24);
      @(negedge clk24);
   endtask

   task automatic main_cmd(input logic [7:0] b);
      snd_latch = b;
      snd_stb   = 1'b1;
      tick(); tick();
      snd_stb   = 1'b0;
      tick();
   endtask

   task automatic sound_write(input logic [1:0] a, input logic [7:0] d, input int hold);
      snd_cs = 1'b1; snd_addr = a; snd_dout = d; snd_wr_n = 1'b0;
      repeat (hold) tick();
      snd_cs = 1'b0; snd_wr_n = 1'b1;
      tick();
   endtask

   task automatic sound_read(input logic [1:0] a, output logic [7:0] d);
      snd_cs = 1'b1; snd_addr = a; snd_rd_n = 1'b0;
      tick();
      d = snd_din;
      snd_cs = 1'b0; snd_rd_n = 1'b1;
      tick();
   endtask

   // snd_cpu_rst must stay high for exactly RST_LEN clks after release
   task automatic check_stretch(input string name);
      int bad = -1;
      for (int i = 1; i <= RST_LEN; i++) begin
         tick();
         if (snd_cpu_rst !== (i < RST_LEN) && bad < 0) bad = i;
      end
      n_vec++;
      if (bad >= 0) begin
         n_err++;
         $display("FAIL %s: snd_cpu_rst wrong at clk %0d after release, expected fall at clk %0d",
                  name, bad, RST_LEN);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; snd_rstn = 1'b1;
      tick(); tick();
      n_vec++; if (snd_cpu_rst !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rst: got %b want 1", snd_cpu_rst); end
      n_vec++; if (snd_nmi_n !== 1'b1) begin n_err++; $display("FAIL reset_nmi: got %b want 1", snd_nmi_n); end
      n_vec++; if (snd_flag !== 1'b0) begin n_err++; $display("FAIL reset_flag: got %b want 0", snd_flag); end
      n_vec++; if (main_stb !== 1'b0) begin n_err++; $display("FAIL reset_main_stb: got %b want 0", main_stb); end
      n_vec++; if (main_latch !== 8'h00) begin n_err++; $display("FAIL reset_main_latch: got %h want 00", main_latch); end
      n_vec++; if (snd_din !== 8'hff) begin n_err++; $display("FAIL reset_din: got %h want ff", snd_din); end
      rst = 1'b0;
      check_stretch("reset_stretch");
      n_vec++; if (snd_nmi_n !== 1'b1 || snd_flag !== 1'b0) begin
         n_err++; $display("FAIL post_reset_idle: nmi_n=%b flag=%b want 1/0", snd_nmi_n, snd_flag);
      end
   endtask

   task automatic test_cmd_nmi();
      logic [7:0] d;
      bit seen = 0;
      sound_write(2'd1, 8'h00, 1);
      snd_latch = 8'h5a; snd_stb = 1'b1;
      for (int i = 0; i < 3 && !seen; i++) begin
         tick();
         if (snd_flag === 1'b1 && snd_nmi_n === 1'b0) seen = 1;
      end
      snd_stb = 1'b0; tick();
      n_vec++; if (!seen) begin n_err++; $display("FAIL cmd_nmi_assert: flag=%b nmi_n=%b want 1/0 within 3 clks", snd_flag, snd_nmi_n); end
      sound_read(2'd1, d);
      n_vec++; if (d !== 8'hfd) begin n_err++; $display("FAIL status_pending: got %h want fd", d); end
      sound_read(2'd2, d);
      n_vec++; if (d !== 8'hff) begin n_err++; $display("FAIL read_addr2: got %h want ff", d); end
      sound_read(2'd0, d);
      n_vec++; if (d !== 8'h5a) begin n_err++; $display("FAIL cmd_read: got %h want 5a", d); end
      n_vec++; if (snd_flag !== 1'b0 || snd_nmi_n !== 1'b1) begin
         n_err++; $display("FAIL cmd_clear: flag=%b nmi_n=%b want 0/1", snd_flag, snd_nmi_n);
      end
   endtask

   task automatic test_reply();
      int pulses = 0;
      logic [7:0] d;
      snd_cs = 1'b1; snd_addr = 2'd0; snd_dout = 8'hc3; snd_wr_n = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(); pulses += int'(main_stb); end
      snd_cs = 1'b0; snd_wr_n = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); pulses += int'(main_stb); end
      n_vec++; if (pulses != 1) begin n_err++; $display("FAIL reply_pulses: got %0d want 1", pulses); end
      n_vec++; if (main_latch !== 8'hc3) begin n_err++; $display("FAIL reply_latch: got %h want c3", main_latch); end
      sound_read(2'd1, d);
      n_vec++; if (d !== 8'hfe) begin n_err++; $display("FAIL status_seen: got %h want fe", d); end
   endtask

   task automatic test_nmi_enable();
      logic [7:0] d;
      sound_write(2'd2, 8'h00, 1);
      main_cmd(8'h11);
      n_vec++; if (snd_nmi_n !== 1'b1 || snd_flag !== 1'b1) begin
         n_err++; $display("FAIL nmi_disabled: nmi_n=%b flag=%b want 1/1", snd_nmi_n, snd_flag);
      end
      snd_cs = 1'b1; snd_addr = 2'd1; snd_wr_n = 1'b0;
      tick();
      n_vec++; if (snd_nmi_n !== 1'b0) begin n_err++; $display("FAIL nmi_enable_late: got %b want 0", snd_nmi_n); end
      snd_cs = 1'b0; snd_wr_n = 1'b1; tick();
      sound_read(2'd0, d);
      n_vec++; if (d !== 8'h11) begin n_err++; $display("FAIL nmi_cmd_read: got %h want 11", d); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      main_cmd(8'h22);
      snd_latch = 8'h33; snd_stb = 1'b1;
      snd_cs = 1'b1; snd_addr = 2'd0; snd_rd_n = 1'b0;
      tick();
      d = snd_din;
      n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL b2b_read: got %h want 22", d); end
      n_vec++; if (snd_flag !== 1'b1) begin n_err++; $display("FAIL b2b_flag: got %b want 1", snd_flag); end
      snd_cs = 1'b0; snd_rd_n = 1'b1; snd_stb = 1'b0; tick();
      sound_read(2'd0, d);
      n_vec++; if (d !== 8'h33 || snd_flag !== 1'b0) begin
         n_err++; $display("FAIL b2b_second: got %h flag=%b want 33/0", d, snd_flag);
      end
   endtask

   task automatic test_rstn_mid_read();
      logic [7:0] d;
      main_cmd(8'h44);
      snd_rstn = 1'b0; tick();
      snd_cs = 1'b1; snd_addr = 2'd0; snd_rd_n = 1'b0;
      tick(); tick(); tick();
      snd_cs = 1'b0; snd_rd_n = 1'b1; tick();
      n_vec++; if (snd_cpu_rst !== 1'b1 || snd_flag !== 1'b1) begin
         n_err++; $display("FAIL rstn_hold: cpu_rst=%b flag=%b want 1/1", snd_cpu_rst, snd_flag);
      end
      snd_rstn = 1'b1;
      check_stretch("rstn_stretch");
      n_vec++; if (snd_flag !== 1'b1 || snd_nmi_n !== 1'b1) begin
         n_err++; $display("FAIL rstn_after: flag=%b nmi_n=%b want 1/1", snd_flag, snd_nmi_n);
      end
      sound_read(2'd0, d);
      n_vec++; if (d !== 8'h44) begin n_err++; $display("FAIL rstn_cmd: got %h want 44", d); end
   endtask

   task automatic test_rst_mid_access();
      main_cmd(8'h66);
      snd_latch = 8'h77; snd_stb = 1'b1;
      snd_cs = 1'b1; snd_addr = 2'd0; snd_rd_n = 1'b0;
      rst = 1'b1; tick();
      n_vec++; if (snd_flag !== 1'b0 || snd_cpu_rst !== 1'b1) begin
         n_err++; $display("FAIL rst_mid: flag=%b cpu_rst=%b want 0/1", snd_flag, snd_cpu_rst);
      end
      tick();
      rst = 1'b0;
      check_stretch("rst_mid_stretch");
      tick();
      n_vec++; if (snd_flag !== 1'b0) begin n_err++; $display("FAIL rst_no_capture: flag=%b want 0", snd_flag); end
      n_vec++; if (snd_din !== 8'h00) begin n_err++; $display("FAIL rst_cmd_cleared: got %h want 00", snd_din); end
      snd_cs = 1'b0; snd_rd_n = 1'b1; snd_stb = 1'b0; tick();
   endtask

`ifdef JTBUBL_SNDFIFO_EN
   task automatic test_fifo();
      logic [7:0] d;
      for (int i = 1; i <= 5; i++) main_cmd(8'(i));
      sound_read(2'd1, d);
      n_vec++; if (d[7] !== 1'b1) begin n_err++; $display("FAIL fifo_ovf: got %b want 1", d[7]); end
      for (int i = 1; i <= 4; i++) begin
         sound_read(2'd0, d);
         n_vec++; if (d !== 8'(i)) begin n_err++; $display("FAIL fifo_pop%0d: got %h want %h", i, d, 8'(i)); end
      end
      n_vec++; if (snd_flag !== 1'b0) begin n_err++; $display("FAIL fifo_empty: flag=%b want 0", snd_flag); end
   endtask
`endif

   initial begin
      test_reset();
      test_cmd_nmi();
      test_reply();
      test_nmi_enable();
      test_back_to_back();
      test_rstn_mid_read();
      test_rst_mid_access();
`ifdef JTBUBL_SNDFIFO_EN
      test_fifo();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
